// File: rtl/jk_counter_pkg.sv
// JK command encodings ({j,k}) and the JK excitation helper shared by the cell and the counter.
package jk_counter_pkg;

   localparam logic [1:0] JK_HOLD   = 2'b00;
   localparam logic [1:0] JK_RESET  = 2'b01;
   localparam logic [1:0] JK_SET    = 2'b10;
   localparam logic [1:0] JK_TOGGLE = 2'b11;

   // d = (j & ~q) | (~k & q), with cmd ordered {j,k}
   function automatic logic jk_next(input logic [1:0] cmd, input logic q);
      return (cmd[1] & ~q) | (~cmd[0] & q);
   endfunction

endpackage

// File: rtl/jk_cell.sv
// One JK storage bit: D flop with async active-low reset, fed by the JK excitation.
module jk_cell
   import jk_counter_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic j,
   input  logic k,
   input  logic rst_val,
   output logic q
);

   logic r_q;
   logic w_d;

   assign w_d = jk_next({j, k}, r_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q <= rst_val;
      end else begin
         r_q <= w_d;
      end
   end

   assign q = r_q;

endmodule

// File: rtl/jk_sync_counter.sv
// Up/down counter built from a chain of JK cells; define JK_SAT_EN to saturate instead of wrap.
module jk_sync_counter
   import jk_counter_pkg::*;
#(
   parameter int unsigned           WIDTH     = 4,
   parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             ovf
);

   logic [WIDTH-1:0] w_q;
   logic [WIDTH-1:0] w_up_pre;
   logic [WIDTH-1:0] w_dn_pre;
   logic [WIDTH-1:0] w_j;
   logic [WIDTH-1:0] w_k;
   logic             w_tc;
   logic             w_sat;
   logic             w_count;
   logic             r_ovf;

   // Toggle-chain prefixes: bit i toggles when all lower bits are 1 (up) or 0 (down)
   assign w_up_pre[0] = 1'b1;
   assign w_dn_pre[0] = 1'b1;
   for (genvar i = 1; i < WIDTH; i++) begin : g_pre
      assign w_up_pre[i] = &w_q[i-1:0];
      assign w_dn_pre[i] = ~|w_q[i-1:0];
   end

   assign w_tc = ~load & en & (up ? (&w_q) : (~|w_q));

`ifdef JK_SAT_EN
   assign w_sat = w_tc;
`else
   assign w_sat = 1'b0;
`endif

   assign w_count = ~load & en & ~w_sat;

   always_comb begin
      w_j = '0;
      w_k = '0;
      for (int i = 0; i < WIDTH; i++) begin
         logic [1:0] w_cmd;
         w_cmd = JK_HOLD;
         if (load) begin
            w_cmd = load_val[i] ? JK_SET : JK_RESET;
         end else if (w_count) begin
            w_cmd = (up ? w_up_pre[i] : w_dn_pre[i]) ? JK_TOGGLE : JK_HOLD;
         end
         w_j[i] = w_cmd[1];
         w_k[i] = w_cmd[0];
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      jk_cell u_cell (
         .clk     (clk),
         .rst_n   (rst_n),
         .j       (w_j[i]),
         .k       (w_k[i]),
         .rst_val (RESET_VAL[i]),
         .q       (w_q[i])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (load) begin
         r_ovf <= 1'b0;
      end else if (w_tc) begin
         r_ovf <= 1'b1;
      end
   end

   assign q   = w_q;
   assign tc  = w_tc;
   assign ovf = r_ovf;

endmodule

// File: tb/tb_jk_sync_counter.sv
// Directed self-checking bench for jk_sync_counter (WIDTH = 4) and a standalone jk_cell.
module tb_jk_sync_counter;

`ifdef JK_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       up;
   logic       load;
   logic [3:0] load_val;
   logic [3:0] q;
   logic       tc;
   logic       ovf;

   logic       c_rst_n;
   logic       c_j;
   logic       c_k;
   logic       c_q;

   int checks = 0;
   int errors = 0;

   jk_sync_counter #(
      .WIDTH     (4),
      .RESET_VAL (4'd0)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .up       (up),
      .load     (load),
      .load_val (load_val),
      .q        (q),
      .tc       (tc),
      .ovf      (ovf)
   );

   jk_cell u_cell (
      .clk     (clk),
      .rst_n   (c_rst_n),
      .j       (c_j),
      .k       (c_k),
      .rst_val (1'b0),
      .q       (c_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      logic [3:0] exp_q;
      logic       exp_tab [8];
      exp_tab = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

      rst_n = 1'b0; c_rst_n = 1'b0;
      en = 1'b1; up = 1'b1; load = 1'b0; load_val = 4'd0;
      c_j = 1'b0; c_k = 1'b0;

      // 1. reset, then count up
      #2;
      chk("reset_q", q, 0);
      chk("reset_ovf", ovf, 0);
      chk("reset_tc", tc, 0);
      step();
      step();
      chk("reset_clocked_q", q, 0);
      rst_n = 1'b1;
      #1;
      chk("tc_at_0_up", tc, 0);
      for (int n = 1; n <= 15; n++) begin
         step();
         chk("count_up_q", q, n);
         chk("count_up_tc", tc, (n == 15) ? 1 : 0);
      end
      chk("pre_wrap_ovf", ovf, 0);

      // 2. wrap (or saturate) upward
      step();
      chk("wrap_up_q", q, SAT ? 15 : 0);
      chk("wrap_up_ovf", ovf, 1);

      // 3. down from zero
      load = 1'b1; load_val = 4'd0;
      step();
      chk("load0_q", q, 0);
      chk("load0_ovf", ovf, 0);
      load = 1'b0; up = 1'b0; en = 1'b1;
      #1;
      chk("tc_at_0_down", tc, 1);
      step();
      chk("wrap_dn_q", q, SAT ? 0 : 15);
      chk("wrap_dn_ovf", ovf, 1);
      step();
      chk("down_q1", q, SAT ? 0 : 14);
      step();
      chk("down_q2", q, SAT ? 0 : 13);

      // 4. count up to 15 with ovf set, then load beats count
      exp_q = SAT ? 4'd0 : 4'd13;
      up = 1'b1;
      for (int n = 0; n < 20 && exp_q != 4'd15; n++) begin
         step();
         exp_q = exp_q + 4'd1;
         chk("reup_q", q, exp_q);
      end
      chk("reup_ovf_sticky", ovf, 1);
      chk("reup_tc", tc, 1);
      load = 1'b1; load_val = 4'd9;
      #1;
      chk("load_pri_tc", tc, 0);
      step();
      chk("load_pri_q", q, 9);
      chk("load_pri_ovf", ovf, 0);
      load = 1'b0; en = 1'b0;
      for (int n = 0; n < 3; n++) begin
         step();
         chk("hold_q", q, 9);
      end
      chk("hold_tc", tc, 0);

      // 5. async reset mid-operation
      load = 1'b1; load_val = 4'd6;
      step();
      chk("load6_q", q, 6);
      load = 1'b0; en = 1'b1; up = 1'b1;
      step();
      chk("cnt7_q", q, 7);
      step();
      chk("cnt8_q", q, 8);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_q", q, 0);
      chk("mid_rst_ovf", ovf, 0);
      #2 rst_n = 1'b1;
      step();
      chk("resume_q1", q, 1);
      step();
      chk("resume_q2", q, 2);
      load = 1'b1; load_val = 4'd0;
      step();
      load = 1'b0; up = 1'b0;
      step();
      chk("ovf_before_rst", ovf, 1);
      en = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_clears_ovf", ovf, 0);
      chk("rst_clears_q", q, 0);
      #1 rst_n = 1'b1;
      step();
      chk("post_rst_hold_q", q, 0);

      // 6. single-cell truth table
      #1;
      chk("cell_reset_q", c_q, 0);
      c_rst_n = 1'b1;
      for (int q0 = 0; q0 < 2; q0++) begin
         for (int cmd = 0; cmd < 4; cmd++) begin
            c_j = (q0 == 1);
            c_k = (q0 == 0);
            step();
            chk("cell_preset_q", c_q, q0);
            c_j = (cmd >= 2);
            c_k = (cmd % 2 == 1);
            step();
            chk("cell_next_q", c_q, exp_tab[q0*4 + cmd]);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/jk_sync_counter.md
Name: jk_sync_counter

Overview:
- Synchronous up/down binary counter built from per-bit JK storage cells. Each cell is D storage fed by the excitation d = (j & ~q) | (~k & q).
- Sits directly downstream of the D-to-JK excitation logic. It consumes the excitation as the next-state input of its state register, and the register output feeds back as the cell's present state.
- Toggle, set, reset and hold are all expressed as JK commands, so the JK semantics are exercised end to end.

Parameters:
- WIDTH, 4, counter width in bits; legal range 2..32.
- RESET_VAL, 0, value loaded into q on reset; width WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  count enable; sampled at posedge clk.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load; has priority over en.
- load_val  input  WIDTH  value to load.
- q  output  WIDTH  registered count.
- tc  output  1  terminal count; combinational from q, en, up and load.
- ovf  output  1  sticky wrap/saturation flag; registered.

Behaviour:
- **Reset.** While rst_n = 0, immediately and without a clock: q = RESET_VAL, ovf = 0. tc follows its equation from the reset q. Reset asserted mid-count aborts that count with no partial update. The first count occurs at the first posedge after rst_n deasserts.
- **Per-bit JK commands.** Per-bit j_i/k_i are computed combinationally each cycle. On every posedge, q_i <= (j_i & ~q_i) | (~k_i & q_i).
- **Load (load = 1).** j_i = load_val_i, k_i = ~load_val_i, i.e. set or reset per bit. Next cycle q = load_val. This applies regardless of en and up, and load also clears ovf.
- **Count (load = 0, en = 1, up = 1).** j_i = k_i = AND(q[i-1:0]); bit 0 has j = k = 1. Result is q + 1 mod 2^WIDTH.
- **Count (load = 0, en = 1, up = 0).** j_i = k_i = AND(~q[i-1:0]); bit 0 toggles. Result is q - 1 mod 2^WIDTH.
- **Hold (load = 0, en = 0).** All j = k = 0; q holds.
- **Latency.** One cycle from input sample to q update. No pipelining: back-to-back enables count every cycle.
- **tc.** tc = ~load & en & (up ? q == all-ones : q == 0). It indicates that the coming edge wraps (or would wrap).
- **ovf.** Set at the posedge where tc = 1 and the count is applied. It stays set until load or reset.
- **Simultaneous events.**
  - load and en both 1: load wins and ovf is cleared even if tc conditions hold. tc is 0 in that cycle because of the ~load term.
  - up changing between cycles: takes effect immediately; no turnaround cycle.
- **Sizing.** No arithmetic adder: count progression comes solely from the JK toggle chain. Widths are exact and there is no carry-out beyond tc.

Optional Feature:
- **Macro:** JK_SAT_EN.
- **Defined (saturating).** When tc = 1 the counter saturates: all j = k = 0 for that cycle, so q stays at all-ones when counting up, or at 0 when counting down. tc still asserts and ovf still sets. Counting in the opposite direction resumes normally.
- **Undefined (wrapping).** q wraps modulo 2^WIDTH as described in Behaviour.

Decomposition:
- **Package jk_counter_pkg.** Holds the JK command encoding constants: JK_HOLD = 2'b00, JK_RESET = 2'b01, JK_SET = 2'b10, JK_TOGGLE = 2'b11, ordered {j,k}. Also holds a function that maps a {j,k} command and present q to next d.
- **Sub-module jk_cell.** One bit: inputs clk, rst_n, j, k and rst_val; output q. It contains the excitation equation and the async-reset D storage.
- **Top level.** jk_sync_counter instantiates WIDTH jk_cells via generate. It contains the toggle-chain AND prefixes, load muxing, tc, ovf and the saturation gating.

Test Plan:
1. **Reset and count up.** Hold rst_n = 0, then release, with en = 1, up = 1 (WIDTH = 4) → q = 0 during reset, then 1, 2, … 15 on successive edges; tc = 1 only while q = 15.
2. **Wrap up.** From q = 15 with en = 1, up = 1 → q = 0 next edge and ovf = 1. With JK_SAT_EN defined → q stays 15, ovf = 1.
3. **Down from zero.** q = 0, en = 1, up = 0 → tc = 1; q = 15 next edge, ovf = 1. Then q = 14, 13 on the following edges.
4. **Load priority.** q = 15 with en = 1, up = 1, load = 1, load_val = 9 → q = 9 next edge, ovf cleared, tc = 0 that cycle. Then set en = 0 for 3 cycles → q holds 9.
5. **Reset mid-operation.** Load 6, count to 8, then pulse rst_n low between edges → q = 0 and ovf = 0 immediately, with no clock. Counting resumes as 1, 2 after release.
6. **Cell truth table.** Drive one jk_cell through all four {j,k} commands from q = 0 and from q = 1 → next q = q, 0, 1 and ~q respectively.
